dmem_access_ctrl: RTL and testbench

Sequences the MEM stage's accesses to a variable-latency data memory over a req/ack handshake. It detects a load or store in EX/MEM, issues one registered request and holds the pipeline until the memory acknowledges. It then captures read data for MEM/WB and releases the pipeline for exactly one advance cycle. It sits beside the load-use hazard unit; its stall_o is ORed with that unit's stall into the PC, IF/ID, ID/EX and EX/MEM write enables, and it forces a bubble into MEM/WB.

---
 rtl/dmem_access_ctrl_pkg.sv | 14 +
 rtl/dmem_access_ctrl_if.sv | 26 ++
 rtl/dmem_access_ctrl_req_timer.sv | 30 +++
 rtl/dmem_access_ctrl.sv | 127 ++++++++++++
 tb/tb_dmem_access_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared constants and state encoding for the MEM-stage data memory sequencer.
package dmem_access_ctrl_pkg;

  localparam int unsigned DMEM_ADDR_W = 32;
  localparam int unsigned DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } dmemState_t;

endpackage : dmem_access_ctrl_pkg

// File: rtl/dmem_access_ctrl_if.sv
// Request/acknowledge bus between the MEM-stage sequencer and data memory.
interface dmem_access_ctrl_if
  import dmem_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DATA_W = DMEM_DATA_W
);

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );

endinterface : dmem_access_ctrl_if

// File: rtl/dmem_access_ctrl_req_timer.sv
// Saturating cycle counter measuring how long a request has waited for ack.
module dmem_access_ctrl_req_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count;

  // Count waiting cycles; hold at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      count <= '0;
    end else if (enable && (count != MAX_CNT)) begin
      count <= count + CNT_W'(1);
    end
  end

  // Expire on the last permitted waiting cycle.
  assign expire = (count >= LAST_CNT);

endmodule : dmem_access_ctrl_req_timer

// File: rtl/dmem_access_ctrl.sv
// MEM-stage sequencer: one registered request per load/store, pipeline held until ack.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = DMEM_ADDR_W,
  parameter int unsigned DATA_W  = DMEM_DATA_W,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  dmem_access_ctrl_if.master memBus,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall_o,
  output logic              err_o
);

  dmemState_t        state;
  dmemState_t        stateNext;
  logic              access;
  logic              reqNext;
  logic              weNext;
  logic [ADDR_W-1:0] addrNext;
  logic [DATA_W-1:0] wdataNext;
  logic [DATA_W-1:0] rdataNext;
  logic              errNext;
  logic              timerClr;
  logic              timerEn;
  logic              timerExpire;

  assign access = MemRead_i | MemWrite_i;

  dmem_access_ctrl_req_timer #(
    .TIMEOUT (TIMEOUT)
  ) uReqTimer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear  (timerClr),
    .enable (timerEn),
    .expire (timerExpire)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state, next register values and the combinational stall.
  always_comb begin
    stateNext = state;
    reqNext   = memBus.mem_req_o;
    weNext    = memBus.mem_we_o;
    addrNext  = memBus.mem_addr_o;
    wdataNext = memBus.mem_wdata_o;
    rdataNext = rdata_o;
    errNext   = err_o;
    timerClr  = 1'b0;
    timerEn   = 1'b0;
    stall_o   = 1'b0;

    case (state)
      IDLE: begin
        stall_o = access;
        if (access) begin
          // A load+store combination is treated as a store.
          weNext    = MemWrite_i;
          addrNext  = addr_i;
          wdataNext = wdata_i;
          reqNext   = 1'b1;
          timerClr  = 1'b1;
          stateNext = REQ;
        end
      end
      REQ: begin
        stall_o = 1'b1;
        timerEn = 1'b1;
        // Ack has priority over a coincident timeout.
        if (memBus.mem_ack_i) begin
          if (!memBus.mem_we_o) begin
            rdataNext = memBus.mem_rdata_i;
          end
          reqNext   = 1'b0;
          stateNext = DONE;
        end else if (timerExpire) begin
          reqNext   = 1'b0;
          errNext   = 1'b1;
          stateNext = ERR;
        end
      end
      DONE: begin
        // Release cycle: access is still the same instruction, so never re-request here.
        stall_o   = 1'b0;
        stateNext = IDLE;
      end
      ERR: begin
        stall_o = 1'b1;
      end
    endcase
  end

  // Registered bus and pipeline outputs; they only move on state transitions.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      memBus.mem_req_o   <= 1'b0;
      memBus.mem_we_o    <= 1'b0;
      memBus.mem_addr_o  <= '0;
      memBus.mem_wdata_o <= '0;
      rdata_o            <= '0;
      err_o              <= 1'b0;
    end else begin
      memBus.mem_req_o   <= reqNext;
      memBus.mem_we_o    <= weNext;
      memBus.mem_addr_o  <= addrNext;
      memBus.mem_wdata_o <= wdataNext;
      rdata_o            <= rdataNext;
      err_o              <= errNext;
    end
  end

endmodule : dmem_access_ctrl

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench: unit A uses the default timeout, unit B a timeout of 4.
module tb_dmem_access_ctrl;
  import dmem_access_ctrl_pkg::*;

  logic        clk;
  logic        rstA;
  logic        rstB;
  logic        memRead;
  logic        memWrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdataIn;
  logic [31:0] rdataA;
  logic [31:0] rdataB;
  logic        stallA;
  logic        stallB;
  logic        errA;
  logic        errB;

  int checks;
  int failures;

  dmem_access_ctrl_if busA ();
  dmem_access_ctrl_if busB ();

  assign busA.mem_rdata_i = rdataIn;
  assign busB.mem_rdata_i = rdataIn;

  dmem_access_ctrl #(.TIMEOUT(64)) dutA (
    .clk_i      (clk),
    .rst_i      (rstA),
    .MemRead_i  (memRead),
    .MemWrite_i (memWrite),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .memBus     (busA),
    .rdata_o    (rdataA),
    .stall_o    (stallA),
    .err_o      (errA)
  );

  dmem_access_ctrl #(.TIMEOUT(4)) dutB (
    .clk_i      (clk),
    .rst_i      (rstB),
    .MemRead_i  (memRead),
    .MemWrite_i (memWrite),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .memBus     (busB),
    .rdata_o    (rdataB),
    .stall_o    (stallB),
    .err_o      (errB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstA = 1'b1; rstB = 1'b1;
    memRead = 1'b0; memWrite = 1'b0; addr = '0; wdata = '0; rdataIn = '0;
    busA.mem_ack_i = 1'b0; busB.mem_ack_i = 1'b0;
    cyc(); cyc();
    rstA = 1'b0;
    #1;
    checks++;
    if (busA.mem_req_o !== 1'b0 || busA.mem_we_o !== 1'b0 || errA !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl req=%b we=%b err=%b exp=0/0/0", busA.mem_req_o, busA.mem_we_o, errA);
    end
    checks++;
    if (busA.mem_addr_o !== 32'h0 || busA.mem_wdata_o !== 32'h0 || rdataA !== 32'h0) begin
      failures++;
      $display("FAIL reset_data addr=%h wdata=%h rdata=%h exp=0", busA.mem_addr_o, busA.mem_wdata_o, rdataA);
    end
    checks++;
    if (stallA !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall got=%b exp=0", stallA);
    end
  endtask

  task automatic test_load();
    int stalls;
    stalls = 0;
    memRead = 1'b1; addr = 32'h40;
    #1;
    checks++;
    if (stallA !== 1'b1) begin
      failures++;
      $display("FAIL load_idle_stall got=%b exp=1", stallA);
    end
    stalls += int'(stallA);
    cyc();
    checks++;
    if (busA.mem_req_o !== 1'b1 || busA.mem_we_o !== 1'b0 || busA.mem_addr_o !== 32'h40 || stallA !== 1'b1) begin
      failures++;
      $display("FAIL load_req req=%b we=%b addr=%h stall=%b exp=1/0/40/1",
               busA.mem_req_o, busA.mem_we_o, busA.mem_addr_o, stallA);
    end
    stalls += int'(stallA);
    busA.mem_ack_i = 1'b1; rdataIn = 32'hDEADBEEF;
    cyc();
    busA.mem_ack_i = 1'b0; memRead = 1'b0;
    #1;
    checks++;
    if (busA.mem_req_o !== 1'b0 || stallA !== 1'b0 || rdataA !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL load_done req=%b stall=%b rdata=%h exp=0/0/deadbeef", busA.mem_req_o, stallA, rdataA);
    end
    checks++;
    if (stalls != 2 || busA.mem_we_o !== 1'b0 || busA.mem_addr_o !== 32'h40) begin
      failures++;
      $display("FAIL load_stalls stalls=%0d we=%b addr=%h exp=2/0/40", stalls, busA.mem_we_o, busA.mem_addr_o);
    end
    cyc();
  endtask

  task automatic test_store_wait();
    int stalls;
    stalls = 0;
    memWrite = 1'b1; addr = 32'h80; wdata = 32'h12345678;
    #1;
    stalls += int'(stallA);
    cyc();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (busA.mem_req_o !== 1'b1 || busA.mem_we_o !== 1'b1 || busA.mem_wdata_o !== 32'h12345678 ||
          busA.mem_addr_o !== 32'h80) begin
        failures++;
        $display("FAIL store_req_stable cyc=%0d req=%b we=%b wdata=%h addr=%h exp=1/1/12345678/80",
                 i, busA.mem_req_o, busA.mem_we_o, busA.mem_wdata_o, busA.mem_addr_o);
      end
      stalls += int'(stallA);
      if (i == 4) begin
        busA.mem_ack_i = 1'b1; rdataIn = 32'hBAD0BAD0;
      end
      cyc();
    end
    busA.mem_ack_i = 1'b0; memWrite = 1'b0;
    #1;
    checks++;
    if (stallA !== 1'b0 || busA.mem_req_o !== 1'b0) begin
      failures++;
      $display("FAIL store_done stall=%b req=%b exp=0/0", stallA, busA.mem_req_o);
    end
    checks++;
    if (stalls != 6) begin
      failures++;
      $display("FAIL store_stalls got=%0d exp=6", stalls);
    end
    checks++;
    if (rdataA !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL store_rdata_hold got=%h exp=deadbeef", rdataA);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic expReq   [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic expStall [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int reqCount;
    reqCount = 0;
    for (int c = 0; c < 7; c++) begin
      memRead = (c <= 5);
      addr = (c <= 2) ? 32'h100 : 32'h104;
      busA.mem_ack_i = (c == 1) || (c == 4);
      rdataIn = (c == 1) ? 32'h11111111 : 32'h22222222;
      #1;
      checks++;
      if (busA.mem_req_o !== expReq[c] || stallA !== expStall[c]) begin
        failures++;
        $display("FAIL b2b_cycle c=%0d req=%b stall=%b exp=%b/%b", c, busA.mem_req_o, stallA, expReq[c], expStall[c]);
      end
      reqCount += int'(busA.mem_req_o);
      if (c == 4) begin
        checks++;
        if (busA.mem_addr_o !== 32'h104) begin
          failures++;
          $display("FAIL b2b_addr2 got=%h exp=104", busA.mem_addr_o);
        end
      end
      cyc();
    end
    busA.mem_ack_i = 1'b0; memRead = 1'b0;
    checks++;
    if (reqCount != 2 || rdataA !== 32'h22222222) begin
      failures++;
      $display("FAIL b2b_summary reqs=%0d rdata=%h exp=2/22222222", reqCount, rdataA);
    end
  endtask

  task automatic test_timeout();
    rstA = 1'b1; rstB = 1'b0;
    memRead = 1'b1; addr = 32'h200; busB.mem_ack_i = 1'b0;
    #1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busB.mem_req_o !== 1'b1 || errB !== 1'b0) begin
        failures++;
        $display("FAIL timeout_req cyc=%0d req=%b err=%b exp=1/0", i, busB.mem_req_o, errB);
      end
      cyc();
    end
    memRead = 1'b0;
    #1;
    checks++;
    if (busB.mem_req_o !== 1'b0 || errB !== 1'b1 || stallB !== 1'b1) begin
      failures++;
      $display("FAIL timeout_err req=%b err=%b stall=%b exp=0/1/1", busB.mem_req_o, errB, stallB);
    end
    busB.mem_ack_i = 1'b1; rdataIn = 32'h99999999;
    cyc();
    busB.mem_ack_i = 1'b0;
    cyc();
    checks++;
    if (busB.mem_req_o !== 1'b0 || errB !== 1'b1 || stallB !== 1'b1 || rdataB !== 32'h0) begin
      failures++;
      $display("FAIL timeout_late_ack req=%b err=%b stall=%b rdata=%h exp=0/1/1/0",
               busB.mem_req_o, errB, stallB, rdataB);
    end
    rstB = 1'b1;
    cyc();
    rstB = 1'b0;
    #1;
    checks++;
    if (errB !== 1'b0 || stallB !== 1'b0 || busB.mem_req_o !== 1'b0) begin
      failures++;
      $display("FAIL timeout_reset err=%b stall=%b req=%b exp=0/0/0", errB, stallB, busB.mem_req_o);
    end
  endtask

  task automatic test_ack_on_timeout();
    memRead = 1'b1; addr = 32'h300;
    #1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busB.mem_req_o !== 1'b1) begin
        failures++;
        $display("FAIL ackto_req cyc=%0d got=%b exp=1", i, busB.mem_req_o);
      end
      if (i == 3) begin
        busB.mem_ack_i = 1'b1; rdataIn = 32'hCAFEF00D;
      end
      cyc();
    end
    busB.mem_ack_i = 1'b0; memRead = 1'b0;
    #1;
    checks++;
    if (errB !== 1'b0 || stallB !== 1'b0 || rdataB !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL ackto_done err=%b stall=%b rdata=%h exp=0/0/cafef00d", errB, stallB, rdataB);
    end
    cyc(); cyc();
    checks++;
    if (errB !== 1'b0 || busB.mem_req_o !== 1'b0) begin
      failures++;
      $display("FAIL ackto_after err=%b req=%b exp=0/0", errB, busB.mem_req_o);
    end
  endtask

  task automatic test_reset_mid_req();
    rstB = 1'b1; rstA = 1'b0;
    memRead = 1'b1; addr = 32'h400;
    #1;
    cyc();
    checks++;
    if (busA.mem_req_o !== 1'b1) begin
      failures++;
      $display("FAIL midrst_req got=%b exp=1", busA.mem_req_o);
    end
    rstA = 1'b1;
    cyc();
    checks++;
    if (busA.mem_req_o !== 1'b0 || busA.mem_addr_o !== 32'h0) begin
      failures++;
      $display("FAIL midrst_abandon req=%b addr=%h exp=0/0", busA.mem_req_o, busA.mem_addr_o);
    end
    rstA = 1'b0; memRead = 1'b0;
    busA.mem_ack_i = 1'b1; rdataIn = 32'h55555555;
    cyc();
    busA.mem_ack_i = 1'b0;
    #1;
    checks++;
    if (busA.mem_req_o !== 1'b0 || rdataA !== 32'h0 || stallA !== 1'b0 || errA !== 1'b0) begin
      failures++;
      $display("FAIL midrst_late_ack req=%b rdata=%h stall=%b err=%b exp=0/0/0/0",
               busA.mem_req_o, rdataA, stallA, errA);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_load();
    test_store_wait();
    test_back_to_back();
    test_timeout();
    test_ack_on_timeout();
    test_reset_mid_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_dmem_access_ctrl
